// File: rtl/redirect_arbiter_pkg.sv
// Shared types for the redirect arbiter.
// Holds the redirect source encoding, the arbiter FSM states and the
// in-flight prediction queue entry layout.
package redirect_arbiter_pkg;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PRED = 2'd1,
        SRC_MISP = 2'd2,
        SRC_SYS  = 2'd3
    } redirect_src_e;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_PEND    = 2'd2,
        ST_QUIESCE = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } q_entry_t;

endpackage

// File: rtl/redirect_arbiter_pred_queue.sv
// In-flight prediction FIFO.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   push, push_data enqueue an entry (accepted when not full, or when a pop
//                   frees a slot in the same cycle)
//   pop             dequeue the head (ignored when empty)
//   clear           drop every entry; wins over push/pop
//   head            current head entry
//   count           occupancy, log2(DEPTH)+1 bits
//   full, empty     occupancy flags from the registered count
module pred_queue
    import redirect_arbiter_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  q_entry_t                   push_data,
    input  logic                       pop,
    input  logic                       clear,
    output q_entry_t                   head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    q_entry_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clear && !reset) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly PTR_W bits, so wrap modulo DEPTH is free.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/redirect_arbiter.sv
// Arbitrates PC redirects into fetch and sequences the fetch/delay flush.
// Every fetched instruction is recorded with its prediction; ID resolutions
// are matched against the queue head and a mismatch produces a registered
// corrective redirect with flush. Syscall redirects win over everything and
// leave the predictor disabled until the queue has drained.
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   STALL                 decode freeze; IF and delay stages hold
//   fetch_valid, fetch_pc IF instruction this cycle
//   pred_take, pred_pc    predictor redirect request and target
//   res_valid, res_pc, res_taken, res_next_pc   ID resolution
//   sys_req, sys_pc       syscall redirect pulse and target
//   Request_Alt_PC, Alt_PC  redirect IF to Alt_PC
//   FLUSH                 squash IF and all delay stages
//   fetch_hold            queue full, IF must not advance
//   mispredict_cnt        saturating count of corrective redirects
//   err                   sticky resolution-on-empty / PC-mismatch flag
//
// state   | meaning
// RUN     | normal fetch, predictor redirects pass through combinationally
// ISSUE   | corrective/syscall redirect + flush driven from latched target
// PEND    | redirect + flush held while decode is stalled
// QUIESCE | after a syscall: predictor off until the queue is empty
module redirect_arbiter
    import redirect_arbiter_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             STALL,
    input  logic             fetch_valid,
    input  logic [31:0]      fetch_pc,
    input  logic             pred_take,
    input  logic [31:0]      pred_pc,
    input  logic             res_valid,
    input  logic [31:0]      res_pc,
    input  logic             res_taken,
    input  logic [31:0]      res_next_pc,
    input  logic             sys_req,
    input  logic [31:0]      sys_pc,
    output logic             Request_Alt_PC,
    output logic [31:0]      Alt_PC,
    output logic             FLUSH,
    output logic             fetch_hold,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic             err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    arb_state_e       state_q, state_d;
    redirect_src_e    src_q, src_d;
    logic [31:0]      alt_q, alt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    q_entry_t         head;
    q_entry_t         push_data;
    logic [PTR_W:0]   q_count;
    logic             q_full;
    logic             q_empty;

    logic issuing;
    logic pred_en;
    logic res_eval;
    logic err_set;
    logic misp;
    logic pred_redirect;
    logic push;
    logic pop;
    logic clear;

    assign issuing  = (state_q == ST_ISSUE) || (state_q == ST_PEND);
    assign pred_en  = (state_q == ST_RUN);

    // Resolutions arriving while a redirect is in flight belong to squashed
    // work; the queue has already been cleared for them.
    assign res_eval = res_valid & ~issuing;
    assign err_set  = res_eval & (q_empty | (head.pc != res_pc));
    assign misp     = res_eval & (q_empty
                                  | (head.pc != res_pc)
                                  | (head.taken != res_taken)
                                  | (head.taken & (head.target != res_next_pc)));

    assign pred_redirect = pred_take & pred_en & ~sys_req & ~misp & ~RESET;

    assign pop   = res_eval;
    assign clear = sys_req | misp;
    assign push  = fetch_valid & ~STALL & ~FLUSH & (~q_full | pop);

    always_comb begin
        push_data        = '0;
        push_data.pc     = fetch_pc;
        push_data.taken  = pred_take & pred_en;
        push_data.target = pred_pc;
    end

    pred_queue #(
        .DEPTH(DEPTH)
    ) u_pred_queue (
        .clk       (CLK),
        .reset     (RESET),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .clear     (clear),
        .head      (head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        alt_d   = alt_q;

        if (sys_req) begin
            src_d = SRC_SYS;
            alt_d = sys_pc;
        end else if (misp) begin
            src_d = SRC_MISP;
            alt_d = res_next_pc;
        end

        case (state_q)
            ST_RUN, ST_QUIESCE: begin
                if (sys_req || misp) begin
                    state_d = ST_ISSUE;
                end else if (state_q == ST_QUIESCE && q_empty && !push && !res_valid) begin
                    state_d = ST_RUN;
                end
            end
            ST_ISSUE, ST_PEND: begin
                // A fresh syscall re-arms the redirect with its own target.
                if (STALL) begin
                    state_d = ST_PEND;
                end else if (sys_req) begin
                    state_d = ST_ISSUE;
                end else if (src_q == SRC_SYS) begin
                    state_d = ST_QUIESCE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_RUN;
            src_q   <= SRC_NONE;
            alt_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            alt_q   <= alt_d;
            if (misp && !sys_req && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign Request_Alt_PC = (issuing & ~RESET) | pred_redirect;
    assign FLUSH          = issuing & ~RESET;
    assign Alt_PC         = (issuing && !RESET) ? alt_q :
                            pred_redirect       ? pred_pc : 32'h0;
    assign fetch_hold     = (q_count == FULL_CNT);
    assign mispredict_cnt = cnt_q;
    assign err            = err_q;

endmodule
